// File: rtl/decode_stage_if.sv
// Handshake/bundle bus between register-read, decode_stage and execute.
// Branch-resolve signals exist only when DECODE_BRANCH_RESOLVE_EN is defined.
interface decode_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic [XLEN-1:0]       rs_data;
  logic [XLEN-1:0]       rt_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_alu_a;
  logic [XLEN-1:0]       out_alu_b;
  logic [ALU_OP_W-1:0]   out_alu_op;
  logic [REG_ADDR_W-1:0] out_reg_w;
  logic                  out_reg_write_en;
  logic                  out_mem_read;
  logic                  out_mem_write;
  logic                  out_is_branch;
  logic                  out_illegal;
`ifdef DECODE_BRANCH_RESOLVE_EN
  logic                  branch_taken;
  logic [XLEN-1:0]       branch_offset;
`endif

  // Upstream/downstream side of the stage.
  modport master (
    output in_valid, instr, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, out_alu_a, out_alu_b, out_alu_op, out_reg_w,
           out_reg_write_en, out_mem_read, out_mem_write, out_is_branch, out_illegal
`ifdef DECODE_BRANCH_RESOLVE_EN
    , input branch_taken, branch_offset
`endif
  );

  // The decode stage itself.
  modport slave (
    input  in_valid, instr, rs_data, rt_data, out_ready,
    output in_ready, out_valid, out_alu_a, out_alu_b, out_alu_op, out_reg_w,
           out_reg_write_en, out_mem_read, out_mem_write, out_is_branch, out_illegal
`ifdef DECODE_BRANCH_RESOLVE_EN
    , output branch_taken, branch_offset
`endif
  );
endinterface

// File: rtl/decode_stage.sv
// Registered MIPS control decode with valid/ready handshake, load-use stall and flush.
// Optional branch resolution (branch_taken/branch_offset) under DECODE_BRANCH_RESOLVE_EN.
package decode_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ  = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI  = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LWL = 6'h22, OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24, OP_LHU = 6'h25, OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28, OP_SH  = 6'h29, OP_SWL = 6'h2A, OP_SW  = 6'h2B, OP_SWR = 6'h2E;

  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR   = 6'h25, FN_XOR = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [5:0] ALU_ADD = 6'd0, ALU_SUB = 6'd1, ALU_AND = 6'd2, ALU_OR   = 6'd3;
  localparam logic [5:0] ALU_XOR = 6'd4, ALU_NOR = 6'd5, ALU_SLT = 6'd6, ALU_SLTU = 6'd7;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int ALU_OP_W       = 6,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  localparam int CNT_W = (LOAD_USE_STALL > 0) ? $clog2(LOAD_USE_STALL + 1) : 1;

  typedef struct packed {
    logic [XLEN-1:0]       alu_a;
    logic [XLEN-1:0]       alu_b;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [REG_ADDR_W-1:0] reg_w;
    logic                  reg_write_en;
    logic                  mem_read;
    logic                  mem_write;
    logic                  is_branch;
    logic                  illegal;
`ifdef DECODE_BRANCH_RESOLVE_EN
    logic                  branch_taken;
    logic [XLEN-1:0]       branch_offset;
`endif
  } bundle_t;

  logic [5:0]            opcode, func;
  logic [15:0]           imm16;
  logic [REG_ADDR_W-1:0] rs_idx, rt_idx, rd_idx;

  assign opcode = bus.instr[31:26];
  assign func   = bus.instr[5:0];
  assign imm16  = bus.instr[15:0];
  assign rs_idx = REG_ADDR_W'(bus.instr[25:21]);
  assign rt_idx = REG_ADDR_W'(bus.instr[20:16]);
  assign rd_idx = REG_ADDR_W'(bus.instr[15:11]);

  bundle_t d;
  logic    writes, use_rd, reads_rt, legal;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    d        = '0;
    d.alu_a  = bus.rs_data;
    d.alu_b  = bus.rt_data;
    d.alu_op = ALU_OP_W'(ALU_ADD);
    writes   = 1'b0;
    use_rd   = 1'b0;
    reads_rt = 1'b0;
    legal    = 1'b1;

    case (opcode)
      OP_RTYPE: begin
        writes   = 1'b1;
        use_rd   = 1'b1;
        reads_rt = 1'b1;
        case (func)
          FN_ADD, FN_ADDU: d.alu_op = ALU_OP_W'(ALU_ADD);
          FN_SUB, FN_SUBU: d.alu_op = ALU_OP_W'(ALU_SUB);
          FN_AND:          d.alu_op = ALU_OP_W'(ALU_AND);
          FN_OR:           d.alu_op = ALU_OP_W'(ALU_OR);
          FN_XOR:          d.alu_op = ALU_OP_W'(ALU_XOR);
          FN_NOR:          d.alu_op = ALU_OP_W'(ALU_NOR);
          FN_SLT:          d.alu_op = ALU_OP_W'(ALU_SLT);
          FN_SLTU:         d.alu_op = ALU_OP_W'(ALU_SLTU);
          default:         legal    = 1'b0;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        d.is_branch = 1'b1;
        reads_rt    = 1'b1;
        d.alu_op    = ALU_OP_W'(ALU_SUB);
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        writes  = 1'b1;
        d.alu_b = XLEN'($signed(imm16));
        if (opcode == OP_SLTI)       d.alu_op = ALU_OP_W'(ALU_SLT);
        else if (opcode == OP_SLTIU) d.alu_op = ALU_OP_W'(ALU_SLTU);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        writes  = 1'b1;
        d.alu_b = XLEN'(imm16);
        if (opcode == OP_ANDI)     d.alu_op = ALU_OP_W'(ALU_AND);
        else if (opcode == OP_ORI) d.alu_op = ALU_OP_W'(ALU_OR);
        else                       d.alu_op = ALU_OP_W'(ALU_XOR);
      end
      OP_LUI: begin
        writes  = 1'b1;
        d.alu_a = '0;
        d.alu_b = XLEN'($signed({imm16, 16'h0000}));
      end
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        writes     = 1'b1;
        d.mem_read = 1'b1;
        d.alu_b    = XLEN'($signed(imm16));
      end
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: begin
        reads_rt    = 1'b1;
        d.mem_write = 1'b1;
        d.alu_b     = XLEN'($signed(imm16));
      end
      default: legal = 1'b0;
    endcase

    // Illegal encodings still flow down the pipe, but as a harmless ADD with no side effects.
    d.illegal = !legal;
    if (!legal) d.alu_op = ALU_OP_W'(ALU_ADD);
    d.reg_w        = use_rd ? rd_idx : rt_idx;
    d.reg_write_en = writes && legal && (d.reg_w != '0);

`ifdef DECODE_BRANCH_RESOLVE_EN
    d.branch_taken  = ((opcode == OP_BEQ) && (bus.rs_data == bus.rt_data)) ||
                      ((opcode == OP_BNE) && (bus.rs_data != bus.rt_data));
    d.branch_offset = XLEN'($signed({imm16, 2'b00}));
`endif
  end

  bundle_t               out_q;
  logic                  out_valid_q;
  logic [CNT_W-1:0]      cnt;
  logic [REG_ADDR_W-1:0] load_dst;
  logic                  hazard, xfer;

  assign hazard = (cnt != '0) &&
                  ((rs_idx == load_dst) || (reads_rt && (rt_idx == load_dst)));
  assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard && !flush;
  assign xfer         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cnt         <= '0;
      load_dst    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      cnt         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (xfer) begin
        out_q       <= d;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (xfer && d.mem_read && (rt_idx != '0)) begin
        load_dst <= rt_idx;
        cnt      <= CNT_W'(LOAD_USE_STALL);
      end else if ((cnt != '0) && bus.out_ready) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign bus.out_valid        = out_valid_q;
  assign bus.out_alu_a        = out_q.alu_a;
  assign bus.out_alu_b        = out_q.alu_b;
  assign bus.out_alu_op       = out_q.alu_op;
  assign bus.out_reg_w        = out_q.reg_w;
  assign bus.out_reg_write_en = out_q.reg_write_en;
  assign bus.out_mem_read     = out_q.mem_read;
  assign bus.out_mem_write    = out_q.mem_write;
  assign bus.out_is_branch    = out_q.is_branch;
  assign bus.out_illegal      = out_q.illegal;
`ifdef DECODE_BRANCH_RESOLVE_EN
  assign bus.branch_taken     = out_q.branch_taken;
  assign bus.branch_offset    = out_q.branch_offset;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: two DUTs (LOAD_USE_STALL=1 and 0) share stimulus
// and are compared every cycle against a behavioural model; branch checks under DECODE_BRANCH_RESOLVE_EN.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_stage_if bus0 ();
  decode_stage_if bus1 ();

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
  assign bus0.instr    = instr;     assign bus1.instr    = instr;
  assign bus0.rs_data  = rs_data;   assign bus1.rs_data  = rs_data;
  assign bus0.rt_data  = rt_data;   assign bus1.rt_data  = rt_data;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

  decode_stage #(.LOAD_USE_STALL(1)) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0));
  decode_stage #(.LOAD_USE_STALL(0)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
    logic [4:0]  rw;
    logic        we, mr, mw, br, ill, bt;
    logic [31:0] boff;
  } exp_t;

  typedef struct packed {
    logic       valid;
    exp_t       q;
    logic [3:0] cnt;
    logic [4:0] dst;
  } mstate_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_store_op(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E};
  endfunction

  function automatic exp_t model_decode(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic [5:0]  op  = i[31:26];
    logic [5:0]  fn  = i[5:0];
    logic [15:0] imm = i[15:0];
    logic [31:0] sx  = {{16{imm[15]}}, imm};
    logic [31:0] zx  = {16'h0000, imm};
    bit legal = 1, writes = 0;
    e    = '0;
    e.a  = rs;
    e.b  = rt;
    e.op = ALU_ADD;
    e.rw = (op == 6'h00) ? i[15:11] : i[20:16];
    if (op == 6'h00) begin
      writes = 1;
      case (fn)
        6'h20, 6'h21: e.op = ALU_ADD;
        6'h22, 6'h23: e.op = ALU_SUB;
        6'h24: e.op = ALU_AND;
        6'h25: e.op = ALU_OR;
        6'h26: e.op = ALU_XOR;
        6'h27: e.op = ALU_NOR;
        6'h2A: e.op = ALU_SLT;
        6'h2B: e.op = ALU_SLTU;
        default: legal = 0;
      endcase
    end else if (op == 6'h04 || op == 6'h05) begin
      e.br = 1; e.op = ALU_SUB;
    end else if (op inside {[6'h08:6'h0E]}) begin
      writes = 1;
      e.b = (op >= 6'h0C) ? zx : sx;
      case (op)
        6'h0A: e.op = ALU_SLT;
        6'h0B: e.op = ALU_SLTU;
        6'h0C: e.op = ALU_AND;
        6'h0D: e.op = ALU_OR;
        6'h0E: e.op = ALU_XOR;
        default: e.op = ALU_ADD;
      endcase
    end else if (op == 6'h0F) begin
      writes = 1; e.a = 32'h0; e.b = {imm, 16'h0000};
    end else if (op inside {[6'h20:6'h26]}) begin
      writes = 1; e.mr = 1; e.b = sx;
    end else if (is_store_op(op)) begin
      e.mw = 1; e.b = sx;
    end else begin
      legal = 0;
    end
    e.ill  = !legal;
    e.we   = writes && legal && (e.rw != 5'd0);
    e.bt   = ((op == 6'h04) && (rs == rt)) || ((op == 6'h05) && (rs != rt));
    e.boff = {{14{imm[15]}}, imm, 2'b00};
    return e;
  endfunction

  mstate_t m_st [2];

  function automatic bit exp_in_ready(input int k);
    logic [5:0] op = instr[31:26];
    bit rd_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || is_store_op(op);
    bit hz = (m_st[k].cnt != 0) &&
             ((instr[25:21] == m_st[k].dst) || (rd_rt && (instr[20:16] == m_st[k].dst)));
    return (!m_st[k].valid || out_ready) && !hz && !flush;
  endfunction

  function automatic mstate_t model_next(input int k);
    mstate_t n = m_st[k];
    exp_t    e = model_decode(instr, rs_data, rt_data);
    bit      xfer = in_valid && exp_in_ready(k);
    if (flush) begin
      n.valid = 0;
      n.cnt   = 0;
    end else begin
      if (xfer) begin
        n.q = e; n.valid = 1;
      end else if (out_ready) begin
        n.valid = 0;
      end
      if (xfer && e.mr && (instr[20:16] != 5'd0)) begin
        n.dst = instr[20:16];
        n.cnt = (k == 0) ? 4'd1 : 4'd0;
      end else if ((m_st[k].cnt != 0) && out_ready) begin
        n.cnt = m_st[k].cnt - 4'd1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st[0] <= '0;
      m_st[1] <= '0;
    end else begin
      m_st[0] <= model_next(0);
      m_st[1] <= model_next(1);
    end
  end

  // ---------------- per-cycle compare ----------------
  exp_t act [2];
  logic act_rdy [2];
  logic act_vld [2];

  always_comb begin
    act[0] = '0;
    act[0].a = bus0.out_alu_a; act[0].b = bus0.out_alu_b; act[0].op = bus0.out_alu_op;
    act[0].rw = bus0.out_reg_w; act[0].we = bus0.out_reg_write_en; act[0].mr = bus0.out_mem_read;
    act[0].mw = bus0.out_mem_write; act[0].br = bus0.out_is_branch; act[0].ill = bus0.out_illegal;
    act[1] = '0;
    act[1].a = bus1.out_alu_a; act[1].b = bus1.out_alu_b; act[1].op = bus1.out_alu_op;
    act[1].rw = bus1.out_reg_w; act[1].we = bus1.out_reg_write_en; act[1].mr = bus1.out_mem_read;
    act[1].mw = bus1.out_mem_write; act[1].br = bus1.out_is_branch; act[1].ill = bus1.out_illegal;
`ifdef DECODE_BRANCH_RESOLVE_EN
    act[0].bt = bus0.branch_taken; act[0].boff = bus0.branch_offset;
    act[1].bt = bus1.branch_taken; act[1].boff = bus1.branch_offset;
`endif
    act_rdy[0] = bus0.in_ready; act_rdy[1] = bus1.in_ready;
    act_vld[0] = bus0.out_valid; act_vld[1] = bus1.out_valid;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d.in_ready", k), 64'(act_rdy[k]), 64'(exp_in_ready(k)));
      check($sformatf("dut%0d.out_valid", k), 64'(act_vld[k]), 64'(m_st[k].valid));
      if (m_st[k].valid) begin
        check($sformatf("dut%0d.alu_a", k), 64'(act[k].a), 64'(m_st[k].q.a));
        check($sformatf("dut%0d.alu_b", k), 64'(act[k].b), 64'(m_st[k].q.b));
        check($sformatf("dut%0d.alu_op", k), 64'(act[k].op), 64'(m_st[k].q.op));
        check($sformatf("dut%0d.reg_w", k), 64'(act[k].rw), 64'(m_st[k].q.rw));
        check($sformatf("dut%0d.flags", k),
              64'({act[k].we, act[k].mr, act[k].mw, act[k].br, act[k].ill}),
              64'({m_st[k].q.we, m_st[k].q.mr, m_st[k].q.mw, m_st[k].q.br, m_st[k].q.ill}));
`ifdef DECODE_BRANCH_RESOLVE_EN
        check($sformatf("dut%0d.branch_taken", k), 64'(act[k].bt), 64'(m_st[k].q.bt));
        check($sformatf("dut%0d.branch_offset", k), 64'(act[k].boff), 64'(m_st[k].q.boff));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [5:0] OPS [23] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                      6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                                      6'h25, 6'h26, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E};
  localparam logic [5:0] FNS [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                      6'h2A, 6'h2B};

  function automatic logic [31:0] rand_instr();
    int r = int'($urandom_range(0, 25));
    logic [5:0] op = (r < 23) ? OPS[r] : 6'($urandom);
    logic [5:0] fn = ($urandom_range(0, 7) != 0) ? FNS[$urandom_range(0, 9)] : 6'($urandom);
    logic [4:0] rs = 5'($urandom_range(0, 3));
    logic [4:0] rt = 5'($urandom_range(0, 3));
    logic [4:0] rd = 5'($urandom_range(0, 3));
    if (op == 6'h00) return {op, rs, rt, rd, 5'($urandom), fn};
    return {op, rs, rt, 16'($urandom)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = i;
    rs_data  = a;
    rt_data  = b;
  endtask

  task automatic randomize_inputs();
    in_valid  = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 3) != 0);
    flush     = ($urandom_range(0, 19) == 0);
    instr     = rand_instr();
    rs_data   = $urandom;
    rt_data   = ($urandom_range(0, 3) == 0) ? rs_data : $urandom;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;

    // Hand-computed expectations that pin the model.
    e = model_decode(32'h2008FFFF, 32'h0, 32'h0);
    check("model.addi.b", 64'(e.b), 64'hFFFFFFFF);
    check("model.addi.rw_we", 64'({e.rw, e.we}), 64'({5'd8, 1'b1}));
    e = model_decode(32'h3C081234, 32'h55, 32'h0);
    check("model.lui.ab", 64'({e.a, e.b}), {32'h0, 32'h12340000});
    e = model_decode(32'h0000003F, 32'h0, 32'h0);
    check("model.badfn", 64'({e.ill, e.we, e.op}), 64'({1'b1, 1'b0, ALU_ADD}));

    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", 64'(bus0.out_valid), 64'h0);
    check("reset.alu_ab", {bus0.out_alu_a, bus0.out_alu_b}, 64'h0);
    check("reset.ctrl", 64'({bus0.out_alu_op, bus0.out_reg_w, bus0.out_reg_write_en,
                             bus0.out_mem_read, bus0.out_mem_write, bus0.out_illegal}), 64'h0);
    #2 rst_n = 1'b1;

    for (int c = 0; c < 200; c++) begin
      randomize_inputs();
      tick();
    end

    // Mid-stream asynchronous reset.
    flush = 1'b0; out_ready = 1'b1; present(32'h20090007, 32'h1, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset.out_valid", 64'(bus0.out_valid), 64'h0);
    check("midreset.alu_b", 64'(bus0.out_alu_b), 64'h0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    // addi $8,$0,-1
    present(32'h2008FFFF, 32'h0, 32'h0);
    tick(); in_valid = 1'b0; #3;
    check("addi.out_valid", 64'(bus0.out_valid), 64'h1);
    check("addi.alu_b", 64'(bus0.out_alu_b), 64'hFFFFFFFF);
    check("addi.reg_w", 64'(bus0.out_reg_w), 64'd8);
    check("addi.alu_op", 64'(bus0.out_alu_op), 64'(ALU_ADD));
    check("addi.reg_write_en", 64'(bus0.out_reg_write_en), 64'h1);

    tick(); present(32'h3408FFFF, 32'h77, 32'h0);
    tick(); in_valid = 1'b0; #3;
    check("ori.alu_b", 64'(bus0.out_alu_b), 64'h0000FFFF);

    tick(); present(32'h3C081234, 32'hDEAD, 32'h0);
    tick(); in_valid = 1'b0; #3;
    check("lui.alu_a", 64'(bus0.out_alu_a), 64'h0);
    check("lui.alu_b", 64'(bus0.out_alu_b), 64'h12340000);

    // lw $8,0($9) then dependent add $10,$8,$8.
    tick(); present(32'h8D280000, 32'h100, 32'h0);
    tick(); present(32'h01085020, 32'h7, 32'h7); #3;
    check("loaduse.stall1.in_ready", 64'(bus0.in_ready), 64'h0);
    check("loaduse.nostall.in_ready", 64'(bus1.in_ready), 64'h1);
    tick(); #3;
    check("loaduse.stall1.in_ready_after", 64'(bus0.in_ready), 64'h1);
    check("loaduse.nostall.reg_w", 64'({bus1.out_valid, bus1.out_reg_w}), 64'({1'b1, 5'd10}));
    tick(); in_valid = 1'b0; #3;
    check("loaduse.stall1.reg_w", 64'({bus0.out_valid, bus0.out_reg_w}), 64'({1'b1, 5'd10}));

    // Backpressure: bundle must hold while out_ready is low.
    tick(); present(32'h20090007, 32'h1, 32'h0);
    tick(); out_ready = 1'b0; present(32'h200A0003, 32'h2, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #3;
      check("stall.in_ready", 64'(bus0.in_ready), 64'h0);
      check("stall.hold", 64'({bus0.out_valid, bus0.out_reg_w, bus0.out_alu_b}),
            64'({1'b1, 5'd9, 32'h7}));
      tick();
    end
    out_ready = 1'b1; #3;
    check("release.in_ready", 64'(bus0.in_ready), 64'h1);
    tick(); in_valid = 1'b0; #3;
    check("release.next", 64'({bus0.out_reg_w, bus0.out_alu_b}), 64'({5'd10, 32'h3}));

    // Flush with a pending load-use stall and a held bundle.
    tick(); present(32'h8D280000, 32'h100, 32'h0);
    tick(); out_ready = 1'b0; flush = 1'b1; present(32'h01085020, 32'h7, 32'h7); #3;
    check("flush.in_ready", 64'(bus0.in_ready), 64'h0);
    tick(); flush = 1'b0; #3;
    check("flush.out_valid", 64'(bus0.out_valid), 64'h0);
    check("flush.cnt_cleared", 64'(bus0.in_ready), 64'h1);
    tick(); in_valid = 1'b0; out_ready = 1'b1;

    // Illegal func and write to $0.
    tick(); present(32'h0000003F, 32'h3, 32'h4);
    tick(); in_valid = 1'b0; #3;
    check("badfn.illegal", 64'({bus0.out_illegal, bus0.out_reg_write_en}), 64'({1'b1, 1'b0}));
    tick(); present(32'h00000020, 32'h3, 32'h4);
    tick(); in_valid = 1'b0; #3;
    check("add0.reg_write_en", 64'({bus0.out_illegal, bus0.out_reg_write_en}), 64'h0);

    // BEQ $0,$0,+3 with equal operands.
    tick(); present(32'h10000003, 32'h5, 32'h5);
    tick(); in_valid = 1'b0; #3;
    check("beq.branch_op", 64'({bus0.out_is_branch, bus0.out_alu_op, bus0.out_reg_write_en}),
          64'({1'b1, ALU_SUB, 1'b0}));
`ifdef DECODE_BRANCH_RESOLVE_EN
    check("beq.branch_taken", 64'(bus0.branch_taken), 64'h1);
    check("beq.branch_offset", 64'(bus0.branch_offset), 64'd12);
    tick(); present(32'h14000003, 32'h5, 32'h5);
    tick(); in_valid = 1'b0; #3;
    check("bne.branch_taken", 64'(bus0.branch_taken), 64'h0);
`endif

    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
